// File: rtl/bolt_pkg.sv
// Shared types and sizes for the bolt (projectile) scheduler.
package bolt_pkg;

    localparam int unsigned NUM_BOLTS = 4;
    localparam int unsigned BOLT_W    = 4;
    localparam int unsigned BOLT_H    = 16;
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned IDX_W     = 2;

    typedef enum logic {
        PLAYER = 1'b0,
        ALIEN  = 1'b1
    } bolt_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        ALLOC = 2'd2
    } bolt_state_e;

    // Top-left position of a bolt being spawned
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } bolt_pos_t;

endpackage

// File: rtl/bolt_scheduler_if.sv
// Fire requests, collision kills and per-slot bolt outputs of the scheduler.
interface bolt_scheduler_if;
    import bolt_pkg::*;

    logic                              startOfFrame;
    logic                              playerFire;
    logic [COORD_W-1:0]                playerX;
    logic [COORD_W-1:0]                playerY;
    logic                              alienFire;
    logic [COORD_W-1:0]                alienX;
    logic [COORD_W-1:0]                alienY;
    logic [NUM_BOLTS-1:0]              hitClear;
    logic [NUM_BOLTS-1:0][COORD_W-1:0] boltTLX;
    logic [NUM_BOLTS-1:0][COORD_W-1:0] boltTLY;
    logic [NUM_BOLTS-1:0]              boltActive;
    logic [NUM_BOLTS-1:0]              boltType;
    logic                              playerAck;
    logic                              alienAck;
    logic                              busy;

    // Game side: frame timing, cannons, collision logic
    modport master (
        output startOfFrame, playerFire, playerX, playerY,
        output alienFire, alienX, alienY, hitClear,
        input  boltTLX, boltTLY, boltActive, boltType,
        input  playerAck, alienAck, busy
    );

    // Scheduler side
    modport slave (
        input  startOfFrame, playerFire, playerX, playerY,
        input  alienFire, alienX, alienY, hitClear,
        output boltTLX, boltTLY, boltActive, boltType,
        output playerAck, alienAck, busy
    );

endinterface

// File: rtl/bolt_slot_alloc.sv
// Lowest-free-slot finder over the slot mask (combinational).
module bolt_slot_alloc
    import bolt_pkg::*;
(
    input  logic [NUM_BOLTS-1:0] free_i,
    output logic [IDX_W-1:0]     idx_c_o,
    output logic                 found_c_o
);

    // Scan from the top so the lowest free index is the last one written
    always_comb begin
        idx_c_o   = '0;
        found_c_o = 1'b0;
        for (int i = NUM_BOLTS - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                idx_c_o   = IDX_W'(i);
                found_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bolt_scheduler.sv
// Projectile slot pool: queues fire requests, moves live bolts once per frame,
// retires off-screen or hit bolts, and allocates slots to new shots.
// Optional build macro BOLT_MULTI_PLAYER_EN lets the player hold up to
// NUM_BOLTS-1 bolts at once (one slot stays reserved for aliens).
module bolt_scheduler #(
    parameter int unsigned NUM_BOLTS     = 4,
    parameter int unsigned PLAYER_SPEED  = 8,
    parameter int unsigned ALIEN_SPEED   = 4,
    parameter int unsigned SCREEN_BOTTOM = 479,
    parameter int unsigned BOLT_H        = 16
) (
    input logic             clk,
    input logic             resetN,
    bolt_scheduler_if.slave bus
);
    import bolt_pkg::*;

    // One extra bit so vertical compares cannot wrap
    localparam int unsigned Y_W = COORD_W + 1;
    localparam logic [Y_W-1:0] P_SPD   = Y_W'(PLAYER_SPEED);
    localparam logic [Y_W-1:0] A_SPD   = Y_W'(ALIEN_SPEED);
    localparam logic [Y_W-1:0] BH_Y    = Y_W'(BOLT_H);
    localparam logic [Y_W-1:0] A_LIMIT = Y_W'(SCREEN_BOTTOM - BOLT_H + 1);

    bolt_state_e                       state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [NUM_BOLTS-1:0][COORD_W-1:0] tlx_q, tlx_d;
    logic [NUM_BOLTS-1:0][COORD_W-1:0] tly_q, tly_d;
    logic [NUM_BOLTS-1:0]              active_q, active_d;
    logic [NUM_BOLTS-1:0]              type_q, type_d;
    logic                              pend_p_q, pend_p_d;
    logic                              pend_a_q, pend_a_d;
    logic                              p_ack_q, p_ack_d;
    logic                              a_ack_q, a_ack_d;
    logic                              busy_q, busy_d;

    logic [NUM_BOLTS-1:0] free0, free1;
    logic [IDX_W-1:0]     p_idx, a_idx;
    logic                 p_found, a_found;
    logic                 player_ok;
    logic                 p_grant, a_grant;
    logic [Y_W-1:0]       cur_y;
    bolt_pos_t            p_spawn, a_spawn;

    // Slots being killed this cycle are not offered for allocation
    assign free0 = ~active_q & ~bus.hitClear;

    bolt_slot_alloc u_alloc_player (
        .free_i    (free0),
        .idx_c_o   (p_idx),
        .found_c_o (p_found)
    );

`ifdef BOLT_MULTI_PLAYER_EN
    localparam int unsigned CNT_W = IDX_W + 1;
    logic [CNT_W-1:0] p_live_cnt;

    // Count live player bolts; the last slot is kept for aliens
    always_comb begin
        p_live_cnt = '0;
        for (int i = 0; i < NUM_BOLTS; i++) begin
            p_live_cnt = p_live_cnt + CNT_W'(active_q[i] & ~type_q[i]);
        end
    end
    assign player_ok = (p_live_cnt < CNT_W'(NUM_BOLTS - 1));
`else
    // Classic rule: only one player bolt on screen
    assign player_ok = ~|(active_q & ~type_q);
`endif

    assign p_grant = (state_q == ALLOC) && pend_p_q && p_found && player_ok;
    assign free1   = p_grant ? (free0 & ~(NUM_BOLTS'(1) << p_idx)) : free0;

    bolt_slot_alloc u_alloc_alien (
        .free_i    (free1),
        .idx_c_o   (a_idx),
        .found_c_o (a_found)
    );

    assign a_grant = (state_q == ALLOC) && pend_a_q && a_found;

    // Spawn positions: player bolt sits above the cannon, alien bolt below
    always_comb begin
        p_spawn.x = bus.playerX;
        p_spawn.y = ({1'b0, bus.playerY} < BH_Y) ? '0
                                                : COORD_W'({1'b0, bus.playerY} - BH_Y);
        a_spawn.x = bus.alienX;
        a_spawn.y = bus.alienY + COORD_W'(BOLT_H);
    end

    // Next-state: frame FSM, per-slot move/retire, allocation, kill override
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tlx_d    = tlx_q;
        tly_d    = tly_q;
        active_d = active_q;
        type_d   = type_q;
        pend_p_d = pend_p_q | bus.playerFire;
        pend_a_d = pend_a_q | bus.alienFire;
        p_ack_d  = 1'b0;
        a_ack_d  = 1'b0;
        cur_y    = {1'b0, tly_q[idx_q]};

        case (state_q)
            IDLE: begin
                if (bus.startOfFrame) begin
                    state_d = MOVE;
                    idx_d   = '0;
                end
            end
            MOVE: begin
                if (active_q[idx_q]) begin
                    if (type_q[idx_q] == PLAYER) begin
                        if (cur_y < P_SPD) begin
                            active_d[idx_q] = 1'b0;
                        end else begin
                            tly_d[idx_q] = COORD_W'(cur_y - P_SPD);
                        end
                    end else begin
                        if ((cur_y + A_SPD) > A_LIMIT) begin
                            active_d[idx_q] = 1'b0;
                        end else begin
                            tly_d[idx_q] = COORD_W'(cur_y + A_SPD);
                        end
                    end
                end
                if (idx_q == IDX_W'(NUM_BOLTS - 1)) begin
                    state_d = ALLOC;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ALLOC: begin
                if (p_grant) begin
                    active_d[p_idx] = 1'b1;
                    type_d[p_idx]   = PLAYER;
                    tlx_d[p_idx]    = p_spawn.x;
                    tly_d[p_idx]    = p_spawn.y;
                    pend_p_d        = 1'b0;
                    p_ack_d         = 1'b1;
                end
                if (a_grant) begin
                    active_d[a_idx] = 1'b1;
                    type_d[a_idx]   = ALIEN;
                    tlx_d[a_idx]    = a_spawn.x;
                    tly_d[a_idx]    = a_spawn.y;
                    pend_a_d        = 1'b0;
                    a_ack_d         = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A collision kill beats any move in the same cycle
        for (int i = 0; i < NUM_BOLTS; i++) begin
            if (bus.hitClear[i]) begin
                active_d[i] = 1'b0;
                tlx_d[i]    = tlx_q[i];
                tly_d[i]    = tly_q[i];
                type_d[i]   = type_q[i];
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tlx_q    <= '0;
            tly_q    <= '0;
            active_q <= '0;
            type_q   <= '0;
            pend_p_q <= 1'b0;
            pend_a_q <= 1'b0;
            p_ack_q  <= 1'b0;
            a_ack_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tlx_q    <= tlx_d;
            tly_q    <= tly_d;
            active_q <= active_d;
            type_q   <= type_d;
            pend_p_q <= pend_p_d;
            pend_a_q <= pend_a_d;
            p_ack_q  <= p_ack_d;
            a_ack_q  <= a_ack_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.boltTLX    = tlx_q;
    assign bus.boltTLY    = tly_q;
    assign bus.boltActive = active_q;
    assign bus.boltType   = type_q;
    assign bus.playerAck  = p_ack_q;
    assign bus.alienAck   = a_ack_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bolt_scheduler.sv
// Scoreboard bench for bolt_scheduler: each frame pushes its expected end-of-frame
// picture; a monitor pops and compares it when busy drops.
module tb_bolt_scheduler;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    bolt_scheduler_if bif ();

    bolt_scheduler dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             pack;
        logic             aack;
        logic [3:0]       act;
        logic [3:0]       typ;
        logic [3:0][10:0] x;
        logic [3:0][10:0] y;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endfunction

    function automatic exp_t mk(logic pa, logic aa, logic [3:0] act, logic [3:0] typ,
                                int x3, int x2, int x1, int x0,
                                int y3, int y2, int y1, int y0);
        exp_t e;
        e.pack = pa;
        e.aack = aa;
        e.act  = act;
        e.typ  = typ;
        e.x[3] = 11'(x3); e.x[2] = 11'(x2); e.x[1] = 11'(x1); e.x[0] = 11'(x0);
        e.y[3] = 11'(y3); e.y[2] = 11'(y2); e.y[1] = 11'(y1); e.y[0] = 11'(y0);
        return e;
    endfunction

    function automatic void check_state(string tag, exp_t e);
        chk({tag, "_playerAck"},  int'(bif.playerAck),  int'(e.pack));
        chk({tag, "_alienAck"},   int'(bif.alienAck),   int'(e.aack));
        chk({tag, "_boltActive"}, int'(bif.boltActive), int'(e.act));
        chk({tag, "_boltType"},   int'(bif.boltType),   int'(e.typ));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_TLX%0d", tag, i), int'(bif.boltTLX[i]), int'(e.x[i]));
            chk($sformatf("%s_TLY%0d", tag, i), int'(bif.boltTLY[i]), int'(e.y[i]));
        end
    endfunction

    // Monitor: end of frame is the cycle busy falls; acks must appear only there
    initial begin : monitor
        logic prev_busy;
        int   fnum;
        exp_t e;
        prev_busy = 1'b0;
        fnum      = 0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !bif.busy) begin
                    fnum++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("frame%0d_unexpected", fnum), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_state($sformatf("frame%0d", fnum), e);
                    end
                end else if (bif.playerAck || bif.alienAck) begin
                    chk("stray_ack", int'({bif.playerAck, bif.alienAck}), 0);
                end
                prev_busy = bif.busy;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_p(int x, int y);
        bif.playerX    = 11'(x);
        bif.playerY    = 11'(y);
        bif.playerFire = 1'b1;
        step();
        bif.playerFire = 1'b0;
    endtask

    task automatic fire_a(int x, int y);
        bif.alienX    = 11'(x);
        bif.alienY    = 11'(y);
        bif.alienFire = 1'b1;
        step();
        bif.alienFire = 1'b0;
    endtask

    task automatic kill(logic [3:0] m);
        bif.hitClear = m;
        step();
        bif.hitClear = 4'b0000;
    endtask

    task automatic start_frame();
        bif.startOfFrame = 1'b1;
        step();
        bif.startOfFrame = 1'b0;
    endtask

    // Called in cycle n0 of the frame; busy must drop in cycle 6
    task automatic wait_frame_end(string tag, int n0);
        int n;
        bit done;
        n    = n0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            if (!bif.busy) begin
                done = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        chk({tag, "_len"}, done ? n : -1, 6);
        step();
    endtask

    task automatic run_frame(string tag, exp_t e);
        exp_q.push_back(e);
        start_frame();
        wait_frame_end(tag, 1);
    endtask

    function automatic void check_zero(string tag);
        chk({tag, "_busy"}, int'(bif.busy), 0);
        check_state(tag, mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    initial begin : stim
        resetN           = 1'b0;
        bif.startOfFrame = 1'b0;
        bif.playerFire   = 1'b0;
        bif.alienFire    = 1'b0;
        bif.playerX      = '0;
        bif.playerY      = '0;
        bif.alienX       = '0;
        bif.alienY       = '0;
        bif.hitClear     = '0;
        step();
        step();
        check_zero("reset");
        resetN = 1'b1;
        step();

        // Player shot from (100,400) then four quiet frames
        fire_p(100, 400);
        run_frame("f1", mk(1, 0, 4'b0001, 4'b0000, 0, 0, 0, 100, 0, 0, 0, 384));
        run_frame("f2", mk(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 100, 0, 0, 0, 376));
        run_frame("f3", mk(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 100, 0, 0, 0, 368));
        run_frame("f4", mk(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 100, 0, 0, 0, 360));
        run_frame("f5", mk(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 100, 0, 0, 0, 352));

        // Both fire; player bolt still live so only the alien is granted
        fire_p(100, 400);
        fire_a(200, 300);
        run_frame("f6", mk(0, 1, 4'b0011, 4'b0010, 0, 0, 200, 100, 0, 0, 316, 344));

        // Kill the player bolt in IDLE; pending player shot now lands at TLY 5
        kill(4'b0001);
        bif.playerX = 11'd50;
        bif.playerY = 11'd21;
        fire_a(210, 100);
        run_frame("f7", mk(1, 1, 4'b0111, 4'b0110, 0, 210, 200, 50, 0, 116, 320, 5));

        // Player bolt at TLY 5 retires
        run_frame("f8", mk(0, 0, 4'b0110, 4'b0110, 0, 210, 200, 50, 0, 120, 324, 5));

        fire_a(300, 0);
        run_frame("f9", mk(0, 1, 4'b0111, 4'b0111, 0, 210, 200, 300, 0, 124, 328, 16));

        // One free slot, both fire: player wins, alien stays pending
        fire_p(60, 200);
        fire_a(400, 50);
        run_frame("f10", mk(1, 0, 4'b1111, 4'b0111, 60, 210, 200, 300, 184, 128, 332, 20));

        // Kill slot 2 in the cycle MOVE processes it; alien takes it in ALLOC
        exp_q.push_back(mk(0, 1, 4'b1111, 4'b0111, 60, 400, 200, 300, 176, 66, 336, 24));
        start_frame();
        step();
        step();
        bif.hitClear = 4'b0100;
        step();
        bif.hitClear = 4'b0000;
        chk("hit2_active", int'(bif.boltActive[2]), 0);
        chk("hit2_TLY", int'(bif.boltTLY[2]), 128);
        wait_frame_end("f11", 4);

        // Alien bolt placed at TLY 462: 462 + 4 > 464 so it retires next frame
        kill(4'b0010);
        fire_a(5, 446);
        run_frame("f12", mk(0, 1, 4'b1111, 4'b0111, 60, 400, 5, 300, 168, 70, 462, 28));
        run_frame("f13", mk(0, 0, 4'b1101, 4'b0111, 60, 400, 5, 300, 160, 74, 462, 32));

        // Reset during MOVE idx 2 with a player request pending
        fire_p(60, 200);
        start_frame();
        step();
        step();
        resetN = 1'b0;
        #1;
        check_zero("midreset");
        step();
        step();
        resetN = 1'b1;
        step();

        // Clean frame: pending request was lost
        run_frame("f15", mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));

        // Spawn near the top saturates at 0
        fire_p(100, 10);
        run_frame("f16", mk(1, 0, 4'b0001, 4'b0000, 0, 0, 0, 100, 0, 0, 0, 0));

        step();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bolt_scheduler.md
# bolt_scheduler

Owns the pool of projectile slots for the game. Accepts fire requests from the player cannon and the alien formation, allocates free slots, and advances every live bolt once per video frame. Retires bolts that leave the playfield or are reported hit. Drives per-slot top-left coordinates, valid mask and bolt type straight into the bolt bitmap/rectangle stage.

## Interface
Parameters:
- NUM_BOLTS, 4, slot count; fixed at 4 to match the bitmap stage's packed arrays
- PLAYER_SPEED, 8, pixels per frame a player bolt moves up
- ALIEN_SPEED, 4, pixels per frame an alien bolt moves down
- SCREEN_BOTTOM, 479, last visible line
- BOLT_H, 16, bolt height in pixels

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- playerFire  in  1  fire pulse from the player
- playerX, playerY  in  11 each  player top-left
- alienFire  in  1  fire pulse from the alien shooter
- alienX, alienY  in  11 each  shooting alien's top-left
- hitClear  in  [3:0]  per-slot kill from collision logic
- boltTLX, boltTLY  out  [3:0][10:0]  per-slot top-left
- boltActive  out  [3:0]  slot live
- boltType  out  [3:0]  0 = player (up), 1 = alien (down)
- playerAck, alienAck  out  1  one-cycle grant pulses
- busy  out  1  high when the FSM is not in IDLE

## Operation
- Fire pulses set sticky pendP/pendA flags. A flag clears only on grant or reset.
- FSM states: IDLE → MOVE → ALLOC → IDLE.
- IDLE: on startOfFrame go to MOVE with idx = 0. startOfFrame in any other state is ignored.
- MOVE: one slot per cycle, idx 0..3, then go to ALLOC.
  - Inactive slots are untouched.
  - Player slot: if TLY < PLAYER_SPEED, retire the slot; else TLY -= PLAYER_SPEED.
  - Alien slot: if TLY + ALIEN_SPEED > SCREEN_BOTTOM − BOLT_H + 1, retire the slot; else TLY += ALIEN_SPEED.
  - All compares use 12-bit unsigned arithmetic (no wrap).
- ALLOC: single cycle.
  - Player first: grant if pendP, a slot is free, and no player bolt is live.
  - Alien next: grant if pendA and a slot is still free.
  - Each grant takes the lowest free index.
  - Player spawn: TLX = playerX, TLY = playerY − BOLT_H, saturating at 0.
  - Alien spawn: TLX = alienX, TLY = alienY + BOLT_H.
  - Grant sets boltActive and boltType, clears the pending flag, and pulses the matching ack.
  - If no slot is free, the pending flag is held to the next frame.
- hitClear[i]: clears boltActive[i] in any state, next edge. It wins over a MOVE update or spawn into the same slot in the same cycle; a slot cleared that cycle is not free for allocation.
- A new fire pulse while its flag is already pending is absorbed (no queueing).

## Timing
- Reset values:
  - boltActive = 0, boltType = 0
  - boltTLX = boltTLY = 0
  - acks = 0, busy = 0
  - pendP = pendA = 0
  - FSM = IDLE
- Frame update: startOfFrame at cycle 0 → MOVE occupies cycles 1–4 → ALLOC at cycle 5 → IDLE at cycle 6.
- Outputs are registered and change only on the MOVE/ALLOC edges or on hitClear.
- Ack pulses are asserted in the cycle after the ALLOC edge, width 1.
- Reset asserted mid-frame: all state returns to reset values immediately. Pending requests are lost.

## Configuration
- BOLT_MULTI_PLAYER_EN
  - Undefined: at most one live player bolt (classic rule).
  - Defined: the player may hold up to NUM_BOLTS−1 slots; one slot is always reserved for aliens. The player grant is then gated by a live-player-bolt count instead of the single-bolt check.

## Structure
- bolt_pkg holds:
  - bolt_type_e (PLAYER, ALIEN)
  - bolt_state_e (IDLE, MOVE, ALLOC)
  - NUM_BOLTS, BOLT_W = 4, BOLT_H = 16
- Sub-module bolt_slot_alloc: combinational lowest-free-index finder over a 4-bit mask, returning index plus a found flag. It is instantiated twice in ALLOC; the second instance sees the mask with the first grant applied.

## Test plan
- Reset, then playerFire with playerX = 100, playerY = 400, then startOfFrame → slot 0 active, type 0, TLX = 100, TLY = 384, playerAck at cycle 6.
- Four more frames with no input → slot 0 TLY = 352 after frame 5. A bolt with TLY = 5 at its next MOVE retires.
- playerFire and alienFire in the same frame with 1 free slot → player granted; alienAck absent; alien granted on the next frame after a slot frees.
- Alien bolt at TLY = 462 with ALIEN_SPEED = 4 → 462 + 4 > 464, so the slot retires on the next MOVE.
- hitClear[2] pulsed on the same cycle MOVE processes slot 2 → boltActive[2] = 0 and TLY unchanged.
- resetN pulled low during MOVE (idx = 2) → all outputs zero next cycle; busy = 0; a later startOfFrame runs a clean frame.
